sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
Front end that feeds the combinational Sobel edge operator (sobel_c). It consumes a raster-order pixel stream, buffers two previous image lines, and presents the 8 neighbours of each interior 3x3 window as p0,p1,p2,p3,p5,p6,p7,p8. Its outputs connect directly to sobel_c; the centre pixel p4 is not output.

Parameters:
IMG_W, 64, pixels per line (>=3)
IMG_H, 48, lines per frame (>=3)
PIX_W, 8, input pixel width
OUT_W, 16, output pixel width; pixels are zero-extended (matches sobel_c 16-bit ports)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
pix_in  in  PIX_W  incoming pixel, raster order
pix_valid  in  1  pix_in is accepted this cycle
sof  in  1  qualified by pix_valid; marks this pixel as (row 0, col 0)
p0,p1,p2,p3,p5,p6,p7,p8  out  OUT_W each  window neighbours, zero-extended
win_valid  out  1  p* hold a valid interior window this cycle
frame_done  out  1  one-cycle pulse with the window of the frame's last pixel

Behaviour:
- Reset, async: all outputs 0; row/col counters 0; window registers 0. Line-buffer RAM contents are not reset. Their contents are don't-care because output is gated by row.
- Accepted pixel = pix_valid=1 at a rising edge. When pix_valid=0 nothing changes: counters, RAM and window hold, and win_valid and frame_done are 0 the next cycle.
- Counters: col runs 0..IMG_W-1, then wraps to 0 and row increments. Row runs 0..IMG_H-1. After (IMG_H-1, IMG_W-1), both wrap to 0.
- sof=1 with pix_valid=1: that pixel is forced to (0,0) and counters continue from there. A mid-frame sof aborts the current frame with no frame_done. Line-buffer data is reused but gated, so no output appears until row>=2 of the new frame.
- Line buffers: two IMG_W-deep RAMs addressed by col.
  - lb1 holds row-1 and lb0 holds row-2.
  - On an accepted pixel: read lb1[col] and lb0[col] (old data), then write lb0[col]<=lb1[col] and lb1[col]<=pix_in.
  - Read-during-write returns old data.
- Window: a 3x3 shift array. Each accepted pixel shifts columns left and loads the new right column as {lb0[col], lb1[col], pix_in}.
  - p0/p3/p6 are the left column, top to bottom.
  - p1/p7 are the middle column, top and bottom.
  - p2/p5/p8 are the right column.
  - p8 is the current pixel (row, col). p0 is (row-2, col-2).
- Validity: win_valid=1 on the cycle after an accepted pixel with row>=2 and col>=2. Latency is 1 clock from pixel to window.
  - Border windows are never flagged.
  - Count per frame is (IMG_W-2)*(IMG_H-2).
  - Stale columns from the previous line's end are shifted out before col reaches 2, so there is no cross-line mixing.
- p* are registered and hold their last value while win_valid=0.
- frame_done=1 in the same cycle as the win_valid of pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames with no gap are supported, with or without sof.
- Width rule: p* = {(OUT_W-PIX_W){0}, pixel}. No arithmetic is performed in this block.

Decomposition:
- Shared package/header (sobel_pkg): PIX_W, OUT_W, and the default IMG_W/IMG_H constants. Counter width is clog2(IMG_W) and clog2(IMG_H).
- Sub-module sobel_line_buf: one IMG_W x PIX_W RAM with synchronous write and old-data read. Instantiated twice.
- Top level holds the counters, window shift array, validity logic and frame_done.

Test Plan:
1. IMG_W=8, IMG_H=6, pixel=row*16+col, continuous valid, sof on the first pixel -> first win_valid 1 cycle after pixel (2,2) with p0..p8 = 00,01,02,10,12,20,21,22.
2. Same frame -> exactly 24 win_valid pulses, frame_done once, coinciding with p8=0x57 and p0=0x35.
3. Random pix_valid gaps (~50% duty) -> identical window sequence to test 1/2; no win_valid during stall cycles.
4. sof asserted at pixel (3,4) -> no frame_done for the aborted frame; the next window appears only after new-frame pixel (2,2), with values from the new frame.
5. rst pulsed mid-row 3, then a fresh frame -> all outputs 0 during reset; output matches test 1 afterwards.
6. Two back-to-back frames, the second inverted (0xFF-value) with no sof -> 48 windows, 2 frame_done pulses, and second-frame first window p0=0xFF.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults and helpers for the Sobel window front end.
// Provides the default pixel widths and image geometry, plus a helper that
// sizes the row/column counters.
package sobel_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 48;

    // Counter width for a range of n positions; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of pixel storage, synchronous write, old-data read.
// Ports:
//   clk      rising-edge clock
//   we_i     write enable (one accepted pixel)
//   addr_i   column address, shared by read and write
//   wdata_i  pixel written at addr_i on the clock edge
//   rdata_o  current contents of addr_i; during a write this is the old value
// Contents are not reset; the top level gates any use of stale data.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int W     = DEF_PIX_W,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    // Combinational read sees the pre-edge contents, so a same-cycle write
    // never disturbs the value the window captures.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-stream 3x3 window generator feeding the Sobel operator.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   pix_in, pix_valid   raster-order pixel and its accept strobe
//   sof                 with pix_valid, forces this pixel to (row 0, col 0)
//   p0..p8 (no p4)      registered window neighbours, zero-extended to OUT_W
//   win_valid           p* hold an interior window this cycle
//   frame_done          pulse alongside the window of the frame's last pixel
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [OUT_W-1:0] p0,
    output logic [OUT_W-1:0] p1,
    output logic [OUT_W-1:0] p2,
    output logic [OUT_W-1:0] p3,
    output logic [OUT_W-1:0] p5,
    output logic [OUT_W-1:0] p6,
    output logic [OUT_W-1:0] p7,
    output logic [OUT_W-1:0] p8,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             last_col, last_row;
    logic             wv_q, wv_d, fd_q, fd_d;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    // win_q[r][c]: r=0 is two lines up, c=2 is the newest column.
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];

    // lb1 holds the previous line; its old value cascades into lb0 so lb0
    // always holds the line before that.
    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we_i    (pix_valid),
        .addr_i  (cur_col),
        .wdata_i (pix_in),
        .rdata_o (lb1_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we_i    (pix_valid),
        .addr_i  (cur_col),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    always_comb begin
        // sof relocates the incoming pixel to the frame origin immediately.
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_col = cur_col == CW'(IMG_W - 1);
        last_row = cur_row == RW'(IMG_H - 1);
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        wv_d     = 1'b0;
        fd_d     = 1'b0;
        if (pix_valid) begin
            col_d = last_col ? '0 : cur_col + CW'(1);
            row_d = last_col ? (last_row ? '0 : cur_row + RW'(1)) : cur_row;
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = pix_in;
            // Row/col gating hides stale line-buffer data and the columns
            // left over from the previous line.
            wv_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            fd_d = wv_d && last_row && last_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '{default: '0};
            wv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            wv_q  <= wv_d;
            fd_q  <= fd_d;
        end
    end

    assign p0         = OUT_W'(win_q[0][0]);
    assign p1         = OUT_W'(win_q[0][1]);
    assign p2         = OUT_W'(win_q[0][2]);
    assign p3         = OUT_W'(win_q[1][0]);
    assign p5         = OUT_W'(win_q[1][2]);
    assign p6         = OUT_W'(win_q[2][0]);
    assign p7         = OUT_W'(win_q[2][1]);
    assign p8         = OUT_W'(win_q[2][2]);
    assign win_valid  = wv_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed + randomized bench for sobel_window_gen against an image-array model.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;
    localparam logic [127:0] T1_FIRST = {16'h00, 16'h01, 16'h02, 16'h10, 16'h12, 16'h20, 16'h21, 16'h22};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic [15:0] p0, p1, p2, p3, p5, p6, p7, p8;
    logic        win_valid, frame_done;
    logic [127:0] got;

    int checks = 0;
    int failures = 0;

    logic [7:0]   img [H][W];
    int           mr = 0;
    int           mc = 0;
    bit           e_wv, e_fd;
    logic [127:0] e_win;
    logic [127:0] win_log [$];
    logic [127:0] fd_win;
    int           fd_cnt = 0;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign got = {p0, p1, p2, p3, p5, p6, p7, p8};

    // Neighbours of the pixel at (r,c) taken straight from the stored image.
    function automatic logic [127:0] ref_win(input int r, input int c);
        return {8'h00, img[r-2][c-2], 8'h00, img[r-2][c-1], 8'h00, img[r-2][c],
                8'h00, img[r-1][c-2], 8'h00, img[r-1][c],
                8'h00, img[r][c-2],   8'h00, img[r][c-1],   8'h00, img[r][c]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] px);
        pix_valid = v;
        sof = s;
        pix_in = px;
        @(posedge clk);
        e_wv = 1'b0;
        e_fd = 1'b0;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = px;
            e_wv = (mr >= 2) && (mc >= 2);
            e_fd = e_wv && (mr == H - 1) && (mc == W - 1);
            if (e_wv) e_win = ref_win(mr, mc);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        @(negedge clk);
        chk("win_valid", 128'(win_valid), 128'(e_wv));
        chk("frame_done", 128'(frame_done), 128'(e_fd));
        if (e_wv) chk("window", got, e_win);
        if (win_valid) win_log.push_back(got);
        if (frame_done) begin
            fd_cnt++;
            fd_win = got;
        end
    endtask

    task automatic frame(input bit inv, input bit s, input bit gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] px;
            px = 8'(((i / W) * 16) + (i % W));
            if (inv) px = 8'hFF - px;
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            step(1'b1, s && (i == 0), px);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_p"}, got, '0);
        chk({tag, "_flags"}, 128'({win_valid, frame_done}), '0);
    endtask

    task automatic clear_logs();
        win_log.delete();
        fd_cnt = 0;
        fd_win = '0;
    endtask

    initial begin
        @(negedge clk);
        rst_chk("reset");
        rst = 1'b0;

        clear_logs();
        frame(1'b0, 1'b1, 1'b0, W * H);
        step(1'b0, 1'b0, 8'h00);
        chk("t1_first_win", win_log.size() > 0 ? win_log[0] : '0, T1_FIRST);
        chk("t2_win_count", 128'(win_log.size()), 128'(24));
        chk("t2_fd_count", 128'(fd_cnt), 128'(1));
        chk("t2_fd_p0", 128'(fd_win[127:112]), 128'(16'h35));
        chk("t2_fd_p8", 128'(fd_win[15:0]), 128'(16'h57));

        clear_logs();
        frame(1'b0, 1'b1, 1'b1, W * H);
        step(1'b0, 1'b1, 8'hA5);
        chk("t3_first_win", win_log.size() > 0 ? win_log[0] : '0, T1_FIRST);
        chk("t3_win_count", 128'(win_log.size()), 128'(24));
        chk("t3_fd_count", 128'(fd_cnt), 128'(1));

        clear_logs();
        frame(1'b0, 1'b1, 1'b0, 3 * W + 4);
        win_log.delete();
        frame(1'b1, 1'b1, 1'b0, W * H);
        step(1'b0, 1'b0, 8'h00);
        chk("t4_fd_count", 128'(fd_cnt), 128'(1));
        chk("t4_win_count", 128'(win_log.size()), 128'(24));
        chk("t4_first_p0", win_log.size() > 0 ? 128'(win_log[0][127:112]) : '0, 128'(16'hFF));

        frame(1'b0, 1'b1, 1'b0, 3 * W + 3);
        pix_valid = 1'b0;
        sof = 1'b0;
        #2 rst = 1'b1;
        #1 rst_chk("t5_rst_async");
        @(posedge clk);
        @(negedge clk);
        rst_chk("t5_rst_hold");
        rst = 1'b0;
        mr = 0;
        mc = 0;
        clear_logs();
        frame(1'b0, 1'b0, 1'b0, W * H);
        step(1'b0, 1'b0, 8'h00);
        chk("t5_first_win", win_log.size() > 0 ? win_log[0] : '0, T1_FIRST);
        chk("t5_win_count", 128'(win_log.size()), 128'(24));
        chk("t5_fd_count", 128'(fd_cnt), 128'(1));

        clear_logs();
        frame(1'b0, 1'b1, 1'b0, W * H);
        frame(1'b1, 1'b0, 1'b0, W * H);
        step(1'b0, 1'b0, 8'h00);
        chk("t6_win_count", 128'(win_log.size()), 128'(48));
        chk("t6_fd_count", 128'(fd_cnt), 128'(2));
        chk("t6_f2_first_p0", win_log.size() > 24 ? 128'(win_log[24][127:112]) : '0, 128'(16'hFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
